// File: rtl/inert_seq_pkg.sv
// Shared types and constants for the inertial calibration sequencer.
// Optional motion check (CAL_MOTION_CHK_EN) uses sat_abs16 from here.
package inert_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_START,
    ST_WAIT_DONE,
    ST_DONE,
    ST_FAIL
  } cal_seq_state_t;

  localparam int FAST_SETTLE_SMPLS = 4;
  localparam int FAST_TIMEOUT_CYC  = 512;
  localparam int RETRY_W           = 2;

  // Counter width for a terminal count n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // |v| with the single unrepresentable value -32768 clamped to 32767.
  function automatic logic [15:0] sat_abs16(input logic signed [15:0] v);
    logic signed [15:0] neg;
    neg = -v;
    if (v == 16'sh8000) return 16'h7fff;
    else if (v < 0)     return $unsigned(neg);
    else                return $unsigned(v);
  endfunction

endpackage

// File: rtl/inert_cal_seq_rate_motion_det.sv
// Combinational gyro-rate motion detector, used only when CAL_MOTION_CHK_EN is defined.
module rate_motion_det
  import inert_seq_pkg::*;
#(
  parameter logic [15:0] THRESH = 16'd1000
) (
  input  logic signed [15:0] ptch_rt,
  input  logic signed [15:0] roll_rt,
  input  logic signed [15:0] yaw_rt,
  output logic               motion
);

  always_comb begin
    motion = (sat_abs16(ptch_rt) > THRESH) ||
             (sat_abs16(roll_rt) > THRESH) ||
             (sat_abs16(yaw_rt)  > THRESH);
  end

endmodule

// File: rtl/inert_cal_seq.sv
// Calibration sequencer: settle on vld samples, pulse strt_cal, supervise cal_done with timeout/retry.
// Define CAL_MOTION_CHK_EN to fail attempts that saw excessive gyro rate.
//
// state      | meaning
// IDLE       | waiting for cmd_cal or the post-reset auto request
// SETTLE     | discarding vld samples before starting the integrator
// START      | strt_cal high for one cycle
// WAIT_DONE  | waiting for cal_done, timeout counter running
// DONE       | success: cal_ok set, cal_ack pulsed
// FAIL       | retries exhausted: cal_fail set, cal_ack pulsed
module inert_cal_seq
  import inert_seq_pkg::*;
#(
  parameter bit          FAST_SIM      = 1'b1,
  parameter int          SETTLE_SMPLS  = 64,
  parameter int          TIMEOUT_CYC   = 1000000,
  parameter int          MAX_RETRY     = 3,
  parameter bit          AUTO_CAL      = 1'b1,
  parameter logic [15:0] MOTION_THRESH = 16'd1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_cal,
  input  logic                vld,
  input  logic                cal_done,
  input  logic signed [15:0]  ptch_rt,
  input  logic signed [15:0]  roll_rt,
  input  logic signed [15:0]  yaw_rt,
  output logic                strt_cal,
  output logic                cal_busy,
  output logic                cal_ok,
  output logic                cal_fail,
  output logic                cal_ack,
  output logic [RETRY_W-1:0]  retry_cnt
);

  localparam int SETTLE_N = FAST_SIM ? FAST_SETTLE_SMPLS : SETTLE_SMPLS;
  localparam int TMO_N    = FAST_SIM ? FAST_TIMEOUT_CYC  : TIMEOUT_CYC;
  localparam int SET_W    = cnt_w(SETTLE_N);
  localparam int TMO_W    = cnt_w(TMO_N);

  localparam logic [SET_W-1:0]   SET_LAST  = SET_W'(SETTLE_N - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TMO_N - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  cal_seq_state_t     state_q, state_d;
  logic [SET_W-1:0]   set_cnt_q, set_cnt_d;
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               auto_pend_q, auto_pend_d;
  logic               strt_q, strt_d;
  logic               busy_q, busy_d;
  logic               ok_q, ok_d;
  logic               fail_q, fail_d;
  logic               ack_q, ack_d;
  logic               tainted;

`ifdef CAL_MOTION_CHK_EN
  logic motion;
  logic motion_hit;
  logic taint_q, taint_d;

  rate_motion_det #(.THRESH(MOTION_THRESH)) u_motion_det (
    .ptch_rt (ptch_rt),
    .roll_rt (roll_rt),
    .yaw_rt  (yaw_rt),
    .motion  (motion)
  );

  assign motion_hit = vld && motion &&
                      ((state_q == ST_SETTLE) || (state_q == ST_WAIT_DONE));
  // A hit on the same cycle as cal_done still taints that attempt.
  assign tainted = taint_q || motion_hit;

  always_comb begin
    taint_d = taint_q || motion_hit;
    if ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) taint_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) taint_q <= 1'b0;
    else     taint_q <= taint_d;
  end
`else
  logic unused_rates;
  assign unused_rates = ^{ptch_rt, roll_rt, yaw_rt, MOTION_THRESH};
  assign tainted      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    set_cnt_d   = set_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    retry_d     = retry_q;
    auto_pend_d = auto_pend_q;
    strt_d      = 1'b0;
    busy_d      = busy_q;
    ok_d        = ok_q;
    fail_d      = fail_q;
    ack_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_cal || auto_pend_q) begin
          state_d     = ST_SETTLE;
          set_cnt_d   = '0;
          retry_d     = '0;
          ok_d        = 1'b0;
          fail_d      = 1'b0;
          auto_pend_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (vld) begin
          if (set_cnt_q == SET_LAST) begin
            state_d   = ST_START;
            strt_d    = 1'b1;
            set_cnt_d = '0;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
          end
        end
      end
      ST_START: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (cal_done && !tainted) begin
          state_d = ST_DONE;
          ok_d    = 1'b1;
          ack_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (cal_done || (tmo_cnt_q == TMO_LAST)) begin
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
            ack_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d   = ST_SETTLE;
            retry_d   = retry_q + 1'b1;
            set_cnt_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_FAIL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      set_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      retry_q     <= '0;
      auto_pend_q <= AUTO_CAL;
      strt_q      <= 1'b0;
      busy_q      <= 1'b0;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_cnt_q   <= set_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      retry_q     <= retry_d;
      auto_pend_q <= auto_pend_d;
      strt_q      <= strt_d;
      busy_q      <= busy_d;
      ok_q        <= ok_d;
      fail_q      <= fail_d;
      ack_q       <= ack_d;
    end
  end

  assign strt_cal  = strt_q;
  assign cal_busy  = busy_q;
  assign cal_ok    = ok_q;
  assign cal_fail  = fail_q;
  assign cal_ack   = ack_q;
  assign retry_cnt = retry_q;

endmodule
